radiant_multi_overlord: RTL
===========================

// Module: radiant_multi_overlord
// PURPOSE
//  Parametrised trigger arbiter: qualifies NUM_SRC trigger sources plus a soft trigger, applies per-source
//  prescale, tracks outstanding event slots in the LAB4 readout and applies FIFO-full and soft flow control.
//  Emits the LAB4 trigger, the external trigger-out pulse, dead-trigger flags and deadtime/dead-count monitors.
//  Single clock domain. Sits between the trigger sources and the LAB4 controller/event builder.
// PARAMETERS
//  NUM_SRC       4   trigger sources; bit0 internal, bit1 external, bit2 PPS, rest user
//  NUM_CH        24  LAB4 FIFO channels checked for full
//  NUM_EVT       4   max outstanding (triggered, not yet read out) events
//  PRESCALE_BITS 8   width of each per-source prescale value
//  EXT_LEN_BITS  5   width of ext-out stretch length
//  HOLDOFF       4   cycles (>=1) in HOLDOFF after each accepted trigger
//  CNT_BITS      32  width of dead-trigger and deadtime counters
// PORTS
//  clk_i             in  1                      system clock
//  rst_n_i           in  1                      asynchronous reset, active low
//  global_en_i       in  1                      master trigger enable
//  trig_src_i        in  NUM_SRC                single-cycle source request flags
//  soft_trig_i       in  1                      single-cycle soft trigger
//  en_i              in  NUM_SRC                per-source enable
//  prescale_i        in  NUM_SRC*PRESCALE_BITS  per-source prescale, src k at [k*PRESCALE_BITS +: PRESCALE_BITS]
//  ext_en_i          in  NUM_SRC+1              ext-out enable per source; bit NUM_SRC = soft
//  ext_len_i         in  EXT_LEN_BITS           ext-out pulse = ext_len_i+1 cycles
//  soft_inhibit_i    in  1                      one trigger then wait for soft_clr_i
//  soft_clr_i        in  1                      releases SOFT_WAIT
//  pps_i             in  1                      PPS flag; latches and clears deadtime counter
//  readout_full_i    in  NUM_CH                 LAB4 FIFO full per channel
//  fifo_mask_i       in  NUM_CH                 1 = ignore that channel's full
//  readout_done_i    in  1                      one event read out (single-cycle)
//  trig_o            out 1                      LAB4 trigger pulse
//  trig_src_o        out NUM_SRC+1              bitmap of sources that caused last accepted trigger
//  ext_trig_o        out 1                      external trigger-out
//  deadtrig_o        out 1                      trigger request lost to deadtime
//  trig_done_o       out 1                      event complete pulse to event builder
//  busy_o            out 1                      cannot accept a trigger this cycle
//  soft_waiting_o    out 1                      state == SOFT_WAIT
//  occupancy_o       out $clog2(NUM_EVT+1)      outstanding events
//  dead_cnt_o        out CNT_BITS               lost requests, saturating
//  deadtime_pps_o    out CNT_BITS               dead cycles over last PPS interval
// BEHAVIOUR
//  Reset: state DISABLED; all outputs, counters, prescalers 0.
//  States: DISABLED -(global_en_i)-> ARMED -(accept)-> HOLDOFF -(HOLDOFF cycles)-> ARMED, or SOFT_WAIT if soft_inhibit_i;
//   SOFT_WAIT -(soft_clr_i)-> ARMED; any state -(!global_en_i)-> DISABLED. soft_clr_i outside SOFT_WAIT ignored.
//  Qualified req k = trig_src_i[k] & en_i[k]. Prescaler k counts qualified reqs, passes every (prescale+1)th
//   (0 = all), then restarts; counts regardless of acceptance; held at 0 while DISABLED.
//  full = |(readout_full_i & ~fifo_mask_i). can_accept = ARMED & occupancy<NUM_EVT & !full.
//  Accept: can_accept & (any prescaled req | soft_trig_i). Next cycle: trig_o=1 (1 cycle), trig_src_o = all
//   simultaneous bits (soft at bit NUM_SRC), held until next accept.
//  Dead: global_en_i & !can_accept & (prescaled req | soft_trig_i) -> deadtrig_o 1 cycle later, dead_cnt_o++ (saturate).
//  Occupancy: +1 on accept, -1 on readout_done_i; both same cycle -> unchanged. readout_done_i at occupancy 0
//   ignored, no trig_done_o. Otherwise trig_done_o pulses 1 cycle after readout_done_i. Kept across DISABLED.
//  ext_trig_o: accept with (trig_src bitmap & ext_en_i)!=0 -> high ext_len_i+1 cycles from trig_o cycle; new
//   qualifying accept restarts the count.
//  Deadtime: internal counter ++ each cycle global_en_i & !can_accept (saturating). pps_i: deadtime_pps_o <= count
//   including current cycle, counter <= 0.
//  busy_o = !can_accept (combinational from registered state/occupancy and full).
// STRUCTURE
//  radiant_overlord_pkg: state enum (DISABLED, ARMED, HOLDOFF, SOFT_WAIT), SRC_INT/SRC_EXT/SRC_PPS indices.
//  Sub-module radiant_trig_prescaler (one per source, generate loop); counters/FSM in this module.
// TESTING
//  Reset mid-HOLDOFF -> all outputs 0, DISABLED; global_en_i=1 -> ARMED next cycle.
//  en_i=1, prescale_i[0]=2, 9 trig_src_i[0] pulses spaced >HOLDOFF -> trig_o on 3rd, 6th, 9th; dead_cnt_o=0.
//  NUM_EVT=4, 5 accepts, no readout_done_i -> 5th gives deadtrig_o, occupancy_o=4; readout_done_i -> 3, trig_done_o.
//  Accept and readout_done_i same cycle at occupancy 2 -> stays 2; readout_done_i at 0 -> no trig_done_o.
//  soft_inhibit_i=1, soft trig -> SOFT_WAIT, src0 req -> deadtrig_o; soft_clr_i -> ARMED, next req accepted.
//  readout_full_i[5]=1, fifo_mask_i[5]=0 -> busy_o=1, pps_i after 100 cycles -> deadtime_pps_o=100; mask bit 5 -> busy_o=0.

Source files
------------

// File: rtl/radiant_overlord_pkg.sv
// Shared types for the RADIANT trigger arbiter: FSM states and fixed trigger-source indices.
package radiant_overlord_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_ARMED,
        ST_HOLDOFF,
        ST_SOFT_WAIT
    } state_t;

    localparam int SRC_INT = 0;
    localparam int SRC_EXT = 1;
    localparam int SRC_PPS = 2;

endpackage

// File: rtl/radiant_trig_prescaler.sv
// Per-source prescaler: passes every (prescale+1)th qualified request, cleared while the arbiter is disabled.
module radiant_trig_prescaler #(
    parameter int PRESCALE_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr,
    input  logic                     req,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic                     pass
);

    logic [PRESCALE_BITS-1:0] cnt;

    // >= rather than == so a prescale lowered mid-count cannot strand the counter above it.
    assign pass = req & ~clr & (cnt >= prescale);

    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (req) begin
            cnt <= pass ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/radiant_multi_overlord.sv
// RADIANT trigger arbiter: prescaled source qualification, holdoff/soft-inhibit FSM, LAB4 event occupancy,
// external trigger-out stretching and dead-trigger/deadtime monitors.
module radiant_multi_overlord
    import radiant_overlord_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int NUM_CH        = 24,
    parameter int NUM_EVT       = 4,
    parameter int PRESCALE_BITS = 8,
    parameter int EXT_LEN_BITS  = 5,
    parameter int HOLDOFF       = 4,
    parameter int CNT_BITS      = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             global_en_i,
    input  logic [NUM_SRC-1:0]               trig_src_i,
    input  logic                             soft_trig_i,
    input  logic [NUM_SRC-1:0]               en_i,
    input  logic [NUM_SRC*PRESCALE_BITS-1:0] prescale_i,
    input  logic [NUM_SRC:0]                 ext_en_i,
    input  logic [EXT_LEN_BITS-1:0]          ext_len_i,
    input  logic                             soft_inhibit_i,
    input  logic                             soft_clr_i,
    input  logic                             pps_i,
    input  logic [NUM_CH-1:0]                readout_full_i,
    input  logic [NUM_CH-1:0]                fifo_mask_i,
    input  logic                             readout_done_i,
    output logic                             trig_o,
    output logic [NUM_SRC:0]                 trig_src_o,
    output logic                             ext_trig_o,
    output logic                             deadtrig_o,
    output logic                             trig_done_o,
    output logic                             busy_o,
    output logic                             soft_waiting_o,
    output logic [$clog2(NUM_EVT+1)-1:0]     occupancy_o,
    output logic [CNT_BITS-1:0]              dead_cnt_o,
    output logic [CNT_BITS-1:0]              deadtime_pps_o
);

    localparam int OCC_BITS = $clog2(NUM_EVT + 1);
    localparam int HO_BITS  = $clog2(HOLDOFF + 1);

    state_t                 state, state_nxt;
    logic [HO_BITS-1:0]     ho_cnt;
    logic [OCC_BITS-1:0]    occ;
    logic [NUM_SRC-1:0]     pre;
    logic [NUM_SRC:0]       src_map;
    logic [EXT_LEN_BITS-1:0] ext_cnt;
    logic [CNT_BITS-1:0]    dt_cnt, dt_now;
    logic                   full, can_accept, any_req, accept, dead, occ_dec;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_pre
        radiant_trig_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_pre (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .clr      (state == ST_DISABLED),
            .req      (trig_src_i[k] & en_i[k]),
            .prescale (prescale_i[k*PRESCALE_BITS +: PRESCALE_BITS]),
            .pass     (pre[k])
        );
    end

    assign full       = |(readout_full_i & ~fifo_mask_i);
    assign can_accept = (state == ST_ARMED) && (occ < OCC_BITS'(NUM_EVT)) && !full;
    assign src_map    = {soft_trig_i, pre};
    assign any_req    = |src_map;
    assign accept     = can_accept & any_req;
    assign dead       = global_en_i & ~can_accept & any_req;
    assign occ_dec    = readout_done_i & (occ != '0);

    assign busy_o         = ~can_accept;
    assign soft_waiting_o = (state == ST_SOFT_WAIT);
    assign occupancy_o    = occ;

    // NOTE: next-state takes its default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        if (!global_en_i) begin
            state_nxt = ST_DISABLED;
        end else begin
            case (state)
                ST_DISABLED:  state_nxt = ST_ARMED;
                ST_ARMED:     if (accept) state_nxt = ST_HOLDOFF;
                ST_HOLDOFF:   if (ho_cnt == HO_BITS'(HOLDOFF - 1))
                                  state_nxt = soft_inhibit_i ? ST_SOFT_WAIT : ST_ARMED;
                ST_SOFT_WAIT: if (soft_clr_i) state_nxt = ST_ARMED;
                default:      state_nxt = ST_DISABLED;
            endcase
        end
    end

    always_comb begin
        dt_now = dt_cnt;
        if (global_en_i && !can_accept && dt_cnt != '1) dt_now = dt_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= ST_DISABLED;
            ho_cnt <= '0;
        end else begin
            state  <= state_nxt;
            ho_cnt <= (state == ST_HOLDOFF) ? ho_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_o         <= 1'b0;
            trig_src_o     <= '0;
            deadtrig_o     <= 1'b0;
            dead_cnt_o     <= '0;
            occ            <= '0;
            trig_done_o    <= 1'b0;
            ext_trig_o     <= 1'b0;
            ext_cnt        <= '0;
            dt_cnt         <= '0;
            deadtime_pps_o <= '0;
        end else begin
            trig_o      <= accept;
            deadtrig_o  <= dead;
            trig_done_o <= occ_dec;
            if (accept) trig_src_o <= src_map;
            if (dead && dead_cnt_o != '1) dead_cnt_o <= dead_cnt_o + 1'b1;

            case ({accept, occ_dec})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            // Pulse is high for ext_len_i+1 cycles starting with the trig_o cycle.
            if (accept && |(src_map & ext_en_i)) begin
                ext_trig_o <= 1'b1;
                ext_cnt    <= ext_len_i;
            end else if (ext_cnt != '0) begin
                ext_cnt <= ext_cnt - 1'b1;
            end else begin
                ext_trig_o <= 1'b0;
            end

            if (pps_i) begin
                deadtime_pps_o <= dt_now;
                dt_cnt         <= '0;
            end else begin
                dt_cnt <= dt_now;
            end
        end
    end

endmodule
